// File: rtl/ble_uart_pkg.sv
// Shared constants and state type for the BLE UART receive path.
// Line terminators, default line length and the line-buffer FSM encoding.
package ble_uart_pkg;

  localparam logic [7:0] CHAR_CR      = 8'h0D;
  localparam logic [7:0] CHAR_LF      = 8'h0A;
  localparam int         DEF_LINE_LEN = 16;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_READY   = 1'b1
  } rx_line_state_t;

  function automatic logic is_terminator(input logic [7:0] b);
    return (b == CHAR_CR) || (b == CHAR_LF);
  endfunction

endpackage

// File: rtl/rx_line_mem.sv
// Line storage: DEPTH x 8 with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset; readers only look at addresses below the stored length.
module rx_line_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/rx_line_buffer.sv
// Assembles UART bytes into one CR/LF-terminated line, holds it until the consumer drains it.
// line_ready one cycle after the terminator; bytes arriving while a line is held are dropped.
module rx_line_buffer
  import ble_uart_pkg::*;
#(
  parameter  int MAX_LEN = DEF_LINE_LEN,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rd_en,
  output logic             line_ready,
  output logic [LEN_W-1:0] line_len,
  output logic [7:0]       rd_data,
  output logic             rd_last,
  output logic             overflow,
  output logic             dropped,
  output logic [7:0]       last_byte
);

  localparam int             AW      = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  rx_line_state_t   r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_rd_ptr;
  logic             r_line_ready;
  logic             r_overflow;
  logic             r_dropped;
  logic [7:0]       r_last_byte;

  logic w_is_term;
  logic w_has_room;
  logic w_store;
  logic w_rd_last;

  assign w_is_term  = is_terminator(rx_data);
  assign w_has_room = (r_len < LEN_MAX);
  assign w_store    = (r_state == ST_COLLECT) && rx_valid && !w_is_term && w_has_room;
  assign w_rd_last  = r_line_ready && (r_rd_ptr == (r_len - LEN_ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_COLLECT;
      r_len        <= '0;
      r_rd_ptr     <= '0;
      r_line_ready <= 1'b0;
      r_overflow   <= 1'b0;
      r_dropped    <= 1'b0;
      r_last_byte  <= 8'h00;
    end else begin
      // Includes the cycle of the final pop: the line is still held then.
      r_dropped <= rx_valid && (r_state == ST_READY);
      if (rx_valid) begin
        r_last_byte <= rx_data;
      end

      unique case (r_state)
        ST_COLLECT: begin
          if (rx_valid) begin
            if (w_is_term) begin
              if (r_len != '0) begin
                r_state      <= ST_READY;
                r_line_ready <= 1'b1;
                r_rd_ptr     <= '0;
              end
            end else if (w_has_room) begin
              r_len <= r_len + LEN_ONE;
            end else begin
              r_overflow <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (rd_en) begin
            if (w_rd_last) begin
              r_state      <= ST_COLLECT;
              r_line_ready <= 1'b0;
              r_len        <= '0;
              r_rd_ptr     <= '0;
              r_overflow   <= 1'b0;
            end else begin
              r_rd_ptr <= r_rd_ptr + LEN_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  rx_line_mem #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_store),
    .i_wr_addr (r_len[AW-1:0]),
    .i_wr_data (rx_data),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (rd_data)
  );

  assign line_ready = r_line_ready;
  assign line_len   = r_len;
  assign rd_last    = w_rd_last;
  assign overflow   = r_overflow;
  assign dropped    = r_dropped;
  assign last_byte  = r_last_byte;

endmodule

// File: tb/tb_rx_line_buffer.sv
// Bench for rx_line_buffer: directed scenarios plus randomized traffic against a queue-based line model.
module tb_rx_line_buffer;

  localparam int MAX   = 16;
  localparam int LEN_W = $clog2(MAX + 1);

  logic             clk;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rd_en;
  logic             line_ready;
  logic [LEN_W-1:0] line_len;
  logic [7:0]       rd_data;
  logic             rd_last;
  logic             overflow;
  logic             dropped;
  logic [7:0]       last_byte;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the line as a byte queue plus a few flags.
  logic [7:0] m_line[$];
  bit         m_ready;
  bit         m_ovf;
  bit         m_drop;
  int         m_ptr;
  logic [7:0] m_last;

  rx_line_buffer #(.MAX_LEN(MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rd_en      (rd_en),
    .line_ready (line_ready),
    .line_len   (line_len),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .overflow   (overflow),
    .dropped    (dropped),
    .last_byte  (last_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs from a negedge, advance the model, return at the next negedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r);
    rx_valid = v;
    rx_data  = d;
    rd_en    = r;
    m_drop   = 0;
    if (m_ready) begin
      if (r) begin
        if (m_ptr == m_line.size() - 1) begin
          m_ready = 0;
          m_line.delete();
          m_ptr = 0;
          m_ovf = 0;
        end else begin
          m_ptr++;
        end
      end
      if (v) m_drop = 1;
    end else if (v) begin
      if (d == 8'h0D || d == 8'h0A) begin
        if (m_line.size() > 0) begin
          m_ready = 1;
          m_ptr   = 0;
        end
      end else if (m_line.size() < MAX) begin
        m_line.push_back(d);
      end else begin
        m_ovf = 1;
      end
    end
    if (v) m_last = d;
    @(negedge clk);
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    m_line.delete();
    m_ready = 0;
    m_ovf   = 0;
    m_drop  = 0;
    m_ptr   = 0;
    m_last  = 8'h00;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (line_ready !== 1'b0) begin n_fail++; $display("FAIL reset_line_ready: got %b want 0", line_ready); end
    n_checks++; if (line_len !== '0) begin n_fail++; $display("FAIL reset_line_len: got %0d want 0", line_len); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    n_checks++; if (last_byte !== 8'h00) begin n_fail++; $display("FAIL reset_last_byte: got %h want 00", last_byte); end
    n_checks++; if (rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd_last: got %b want 0", rd_last); end
  endtask

  task automatic test_single_line();
    cycle(1, 8'h41, 0);
    n_checks++; if (line_ready !== 1'b0) begin n_fail++; $display("FAIL single_early_ready: got %b want 0", line_ready); end
    cycle(1, 8'h0A, 0);
    n_checks++; if (line_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", line_ready); end
    n_checks++; if (line_len !== 5'd1) begin n_fail++; $display("FAIL single_len: got %0d want 1", line_len); end
    n_checks++; if (rd_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", rd_data); end
    n_checks++; if (rd_last !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b want 1", rd_last); end
    n_checks++; if (last_byte !== 8'h0A) begin n_fail++; $display("FAIL single_last_byte: got %h want 0a", last_byte); end
    cycle(0, 8'h00, 1);
    n_checks++; if (line_ready !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", line_ready); end
    // A pop with nothing held must change nothing.
    cycle(0, 8'h00, 1);
    n_checks++; if (line_len !== 5'd0 || line_ready !== 1'b0) begin n_fail++; $display("FAIL idle_pop: got len %0d ready %b want 0 0", line_len, line_ready); end
  endtask

  task automatic test_crlf();
    cycle(1, 8'h48, 0);
    cycle(1, 8'h49, 0);
    cycle(1, 8'h0D, 0);
    n_checks++; if (line_ready !== 1'b1 || line_len !== 5'd2) begin n_fail++; $display("FAIL crlf_line: got ready %b len %0d want 1 2", line_ready, line_len); end
    n_checks++; if (rd_data !== 8'h48 || rd_last !== 1'b0) begin n_fail++; $display("FAIL crlf_byte0: got %h last %b want 48 0", rd_data, rd_last); end
    cycle(0, 8'h00, 1);
    n_checks++; if (rd_data !== 8'h49 || rd_last !== 1'b1) begin n_fail++; $display("FAIL crlf_byte1: got %h last %b want 49 1", rd_data, rd_last); end
    cycle(0, 8'h00, 1);
    cycle(1, 8'h0A, 0);
    n_checks++; if (line_ready !== 1'b0 || line_len !== 5'd0) begin n_fail++; $display("FAIL crlf_lf_line: got ready %b len %0d want 0 0", line_ready, line_len); end
    n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL crlf_lf_dropped: got %b want 0", dropped); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) cycle(1, 8'(8'h30 + i), 0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_collect: got %b want 1", overflow); end
    cycle(1, 8'h0A, 0);
    n_checks++; if (line_len !== 5'd16) begin n_fail++; $display("FAIL ovf_len: got %0d want 16", line_len); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rd_data !== 8'(8'h30 + i) || overflow !== 1'b1 || rd_last !== (i == 15)) begin
        n_fail++; $display("FAIL ovf_read[%0d]: got %h ovf %b last %b want %h 1 %b", i, rd_data, overflow, rd_last, 8'(8'h30 + i), (i == 15));
      end
      cycle(0, 8'h00, 1);
    end
    n_checks++; if (overflow !== 1'b0 || line_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got ovf %b ready %b want 0 0", overflow, line_ready); end
  endtask

  task automatic test_dropped();
    cycle(1, 8'h41, 0);
    cycle(1, 8'h0A, 0);
    cycle(1, 8'h55, 0);
    n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b want 1", dropped); end
    n_checks++; if (last_byte !== 8'h55) begin n_fail++; $display("FAIL drop_last_byte: got %h want 55", last_byte); end
    n_checks++; if (line_len !== 5'd1 || rd_data !== 8'h41) begin n_fail++; $display("FAIL drop_held: got len %0d data %h want 1 41", line_len, rd_data); end
    cycle(0, 8'h00, 0);
    n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL drop_one_shot: got %b want 0", dropped); end
    cycle(0, 8'h00, 1);
    cycle(1, 8'h31, 0);
    cycle(1, 8'h0A, 0);
    n_checks++; if (line_len !== 5'd1 || rd_data !== 8'h31) begin n_fail++; $display("FAIL drop_next_line: got len %0d data %h want 1 31", line_len, rd_data); end
    cycle(0, 8'h00, 1);
  endtask

  task automatic test_rst_mid();
    cycle(1, 8'h61, 0);
    cycle(1, 8'h62, 0);
    cycle(1, 8'h63, 0);
    apply_reset();
    n_checks++; if (line_len !== 5'd0 || last_byte !== 8'h00) begin n_fail++; $display("FAIL rst_collect: got len %0d last %h want 0 00", line_len, last_byte); end
    cycle(1, 8'h42, 0);
    cycle(1, 8'h0A, 0);
    n_checks++; if (line_len !== 5'd1 || rd_data !== 8'h42) begin n_fail++; $display("FAIL rst_next_line: got len %0d data %h want 1 42", line_len, rd_data); end
    cycle(0, 8'h00, 1);
    cycle(1, 8'h44, 0);
    cycle(1, 8'h45, 0);
    cycle(1, 8'h0D, 0);
    cycle(0, 8'h00, 1);
    apply_reset();
    n_checks++; if (line_ready !== 1'b0 || line_len !== 5'd0) begin n_fail++; $display("FAIL rst_drain: got ready %b len %0d want 0 0", line_ready, line_len); end
  endtask

  task automatic test_final_rd_drop();
    cycle(1, 8'h41, 0);
    cycle(1, 8'h0A, 0);
    cycle(1, 8'h61, 1);
    n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL final_drop_pulse: got %b want 1", dropped); end
    n_checks++; if (line_ready !== 1'b0 || line_len !== 5'd0) begin n_fail++; $display("FAIL final_drop_empty: got ready %b len %0d want 0 0", line_ready, line_len); end
    n_checks++; if (last_byte !== 8'h61) begin n_fail++; $display("FAIL final_drop_last_byte: got %h want 61", last_byte); end
    cycle(1, 8'h62, 0);
    cycle(1, 8'h0A, 0);
    n_checks++; if (line_len !== 5'd1 || rd_data !== 8'h62) begin n_fail++; $display("FAIL final_drop_next: got len %0d data %h want 1 62", line_len, rd_data); end
    cycle(0, 8'h00, 1);
  endtask

  task automatic test_random();
    bit         v, r;
    logic [7:0] d;
    int         term_odds;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      term_odds = (i < 1500) ? 5 : 30;
      v = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, term_odds - 1) == 0) d = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
      else d = 8'($urandom_range(0, 255));
      n_checks++;
      if (line_ready !== m_ready || overflow !== m_ovf || line_len !== LEN_W'(m_line.size())) begin
        n_fail++; $display("FAIL rand_state[%0d]: got ready %b ovf %b len %0d want %b %b %0d", i, line_ready, overflow, line_len, m_ready, m_ovf, m_line.size());
      end
      if (m_ready) begin
        n_checks++;
        if (rd_data !== m_line[m_ptr] || rd_last !== (m_ptr == m_line.size() - 1)) begin
          n_fail++; $display("FAIL rand_read[%0d]: got %h last %b want %h %b", i, rd_data, rd_last, m_line[m_ptr], (m_ptr == m_line.size() - 1));
        end
      end
      cycle(v, d, r);
      n_checks++;
      if (dropped !== m_drop || last_byte !== m_last) begin
        n_fail++; $display("FAIL rand_post[%0d]: got drop %b last %h want %b %h", i, dropped, last_byte, m_drop, m_last);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_line();
    test_crlf();
    test_overflow();
    test_dropped();
    test_rst_mid();
    test_final_rd_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_line_buffer.md
RX_LINE_BUFFER -- requirements
Module: rx_line_buffer

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum stored payload bytes per line; the legal range is 2..255.
REQ-002 LEN_W SHALL be a localparam equal to $clog2(MAX_LEN+1).
REQ-003 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 rx_data  in  8  SHALL carry the byte from the UART receiver stage.
REQ-006 rx_valid  in  1  SHALL be a one-cycle strobe, one per received byte.
REQ-007 rd_en  in  1  SHALL be the consumer pop request, honoured only while line_ready=1.
REQ-008 line_ready  out  1  SHALL indicate that a complete line is held.
REQ-009 line_len  out  LEN_W  SHALL give the stored byte count of the held line.
REQ-010 rd_data  out  8  SHALL be the byte at the read pointer, combinational from storage.
REQ-011 rd_last  out  1  SHALL be high when the read pointer equals line_len-1 and line_ready=1.
REQ-012 overflow  out  1  SHALL indicate that the held or in-progress line lost bytes.
REQ-013 dropped  out  1  SHALL be a one-cycle pulse when a byte is discarded because a line is pending.
REQ-014 last_byte  out  8  SHALL hold the most recent rx_data accepted on rx_valid, for the LED display.

Function
REQ-015 FSM states SHALL be COLLECT and READY only.
REQ-016 In COLLECT, on rx_valid with a non-terminator byte and len<MAX_LEN, the byte SHALL be written to buf[len] and len incremented.
REQ-017 In COLLECT, on rx_valid with a non-terminator byte and len==MAX_LEN, the byte SHALL be discarded and overflow set; len stays MAX_LEN.
REQ-018 Terminators SHALL be CR (0x0D) and LF (0x0A); terminators are never stored.
REQ-019 A terminator arriving with len==0 SHALL be ignored, so a CR LF pair yields exactly one line.
REQ-020 A terminator arriving with len>0 SHALL cause COLLECT->READY; line_ready SHALL be 1 in the following cycle (latency 1) with the read pointer at 0.
REQ-021 In READY, each rd_en SHALL advance the read pointer by 1.
REQ-022 An rd_en coinciding with rd_last SHALL cause READY->COLLECT on the next cycle, with len, read pointer and overflow cleared.
REQ-023 rd_en while line_ready=0 SHALL have no effect.
REQ-024 In READY, any rx_valid (including a terminator) SHALL be discarded, with dropped=1 in the following cycle.
REQ-025 rx_valid in the same cycle as the final rd_en SHALL be dropped, because the state is still READY in that cycle.
REQ-026 last_byte SHALL update on every rx_valid regardless of state.
REQ-027 overflow SHALL remain high through READY until the line is fully drained.

Reset
REQ-028 When rst=1 at an edge, the block SHALL go to state COLLECT with len=0, read pointer=0, line_ready=0, overflow=0, dropped=0, last_byte=0x00.
REQ-029 Buffer contents SHALL be left uninitialised by reset.
REQ-030 rst asserted mid-collect or mid-drain SHALL abandon the line with no line_ready pulse.
REQ-031 rd_data SHALL be don't-care while line_ready=0.

Structure
REQ-032 Package ble_uart_pkg SHALL hold CHAR_CR=8'h0D, CHAR_LF=8'h0A, DEF_LINE_LEN=16 and the state enum type.
REQ-033 Storage SHALL be one sub-module, rx_line_mem: MAX_LEN x 8, one synchronous write port and one asynchronous read port.
REQ-034 The block SHALL use no other sub-modules.

Verification
REQ-035 Bytes 0x41, 0x0A -> line_ready=1 one cycle after LF; line_len=1; rd_data=0x41; rd_last=1; after rd_en, line_ready=0.
REQ-036 Bytes 0x48, 0x49, 0x0D, 0x0A, with the line drained after the CR -> exactly one line of len 2 (0x48, 0x49); the LF produces no second line.
REQ-037 20 bytes 0x30..0x43 then 0x0A (MAX_LEN=16) -> line_len=16; overflow=1; the last byte read is 0x3F; overflow=0 after the drain.
REQ-038 With a line pending, send 0x55 -> dropped pulses once; the next line excludes 0x55; last_byte=0x55.
REQ-039 After 3 bytes collected, assert rst for 1 cycle, then send 0x42, 0x0A -> line_len=1; rd_data=0x42.
REQ-040 Final rd_en in the same cycle as rx_valid=0x61 -> dropped=1; the following line starts empty; last_byte=0x61.
